// File: rtl/mc_control.sv
// miniRV-1 multi-cycle control sequencer: decode, FSM, memory handshakes,
// trap on illegal instruction or bus timeout, retired-instruction counter.
module mc_control #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      ins,
   input  logic             branch_taken,
   output logic             imem_req,
   input  logic             imem_ack,
   output logic             ir_wen,
   output logic             dmem_req,
   output logic             dmem_we,
   input  logic             dmem_ack,
   output logic             pc_wen,
   output logic             pc_sel,
   output logic [1:0]       wb_sel,
   output logic [2:0]       imm_op,
   output logic [3:0]       alu_op,
   output logic             alua_sel,
   output logic             alub_sel,
   output logic             rf_wen,
   output logic [2:0]       state,
   output logic             trap,
   output logic [1:0]       trap_cause,
   output logic [CNT_W-1:0] retire_cnt
);

   localparam logic [2:0] FETCH  = 3'd0;
   localparam logic [2:0] DECODE = 3'd1;
   localparam logic [2:0] EXEC   = 3'd2;
   localparam logic [2:0] MEM    = 3'd3;
   localparam logic [2:0] WB     = 3'd4;
   localparam logic [2:0] TRAP   = 3'd5;

   localparam int WW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [WW-1:0] TMAX = WW'(MEM_TIMEOUT - 1);

   logic [2:0]       r_state;
   logic             r_trap;
   logic [1:0]       r_cause;
   logic [CNT_W-1:0] r_cnt;
   logic [WW-1:0]    r_wait;

   logic [2:0] w_nxt;
   logic [1:0] w_cause;
   logic       w_retire;
   logic       w_tmo;

   logic [6:0] w_op;
   logic [2:0] w_f3;
   logic [6:0] w_f7;
   logic w_r, w_ia, w_ld, w_jalr, w_st, w_br, w_lui, w_auipc, w_jal;
   logic w_f7ok, w_f7alt, w_shift, w_ill;
   logic [3:0] w_alu;
   logic [2:0] w_imm;
   logic       w_unused;

   logic w_ireq, w_irw, w_dreq, w_dwe, w_pcw, w_pcs, w_rfw;
   logic w_sel_on;

   assign w_op     = ins[6:0];
   assign w_f3     = ins[14:12];
   assign w_f7     = ins[31:25];
   assign w_unused = ^{ins[24:15], ins[11:7]};

   assign w_r     = (w_op == 7'b0110011);
   assign w_ia    = (w_op == 7'b0010011);
   assign w_ld    = (w_op == 7'b0000011);
   assign w_jalr  = (w_op == 7'b1100111);
   assign w_st    = (w_op == 7'b0100011);
   assign w_br    = (w_op == 7'b1100011);
   assign w_lui   = (w_op == 7'b0110111);
   assign w_auipc = (w_op == 7'b0010111);
   assign w_jal   = (w_op == 7'b1101111);

   assign w_f7alt = (w_f7 == 7'b0100000);
   assign w_f7ok  = (w_f7 == 7'b0000000) | w_f7alt;
   assign w_shift = (w_f3 == 3'b001) | (w_f3 == 3'b101);

   assign w_ill =
      ~(w_r | w_ia | w_ld | w_jalr | w_st | w_br | w_lui | w_auipc | w_jal)
      | ((w_ld | w_st) & (w_f3 != 3'b010))
      | (w_br & ((w_f3 == 3'b010) | (w_f3 == 3'b011)))
      | (w_r & ~w_f7ok)
      | (w_r & w_f7alt & (w_f3 != 3'b000) & (w_f3 != 3'b101))
      | (w_ia & w_shift & ~w_f7ok);

   always_comb begin
      w_alu = 4'd0;
      if (w_r | w_ia) begin
         unique case (w_f3)
            3'b000: w_alu = (w_r & w_f7alt) ? 4'd1 : 4'd0;
            3'b111: w_alu = 4'd2;
            3'b110: w_alu = 4'd3;
            3'b100: w_alu = 4'd4;
            3'b001: w_alu = 4'd5;
            3'b101: w_alu = w_f7alt ? 4'd7 : 4'd6;
            3'b010: w_alu = 4'd8;
            3'b011: w_alu = 4'd9;
         endcase
      end
   end

   always_comb begin
      w_imm = 3'd0;
      unique case (1'b1)
         w_ia | w_ld | w_jalr: w_imm = 3'd1;
         w_st:                 w_imm = 3'd2;
         w_br:                 w_imm = 3'd3;
         w_lui | w_auipc:      w_imm = 3'd4;
         w_jal:                w_imm = 3'd5;
         default:              w_imm = 3'd0;
      endcase
   end

   assign w_tmo = (MEM_TIMEOUT != 0) && (r_wait == TMAX);

   // State register and counters
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= FETCH;
         r_trap  <= 1'b0;
         r_cause <= 2'd0;
         r_cnt   <= '0;
         r_wait  <= '0;
      end else begin
         r_state <= w_nxt;
         if (w_nxt == TRAP && r_state != TRAP) begin
            r_trap  <= 1'b1;
            r_cause <= w_cause;
         end
         if (w_retire)
            r_cnt <= r_cnt + CNT_W'(1);
         if (w_nxt != r_state)
            r_wait <= '0;
         else if (r_state == FETCH || r_state == MEM)
            r_wait <= r_wait + WW'(1);
      end
   end

   always_comb begin
      w_nxt   = r_state;
      w_cause = 2'd0;
      unique case (r_state)
         FETCH: begin
            if (imem_ack) w_nxt = DECODE;
            else if (w_tmo) begin
               w_nxt   = TRAP;
               w_cause = 2'd2;
            end
         end
         DECODE: begin
            if (w_ill) begin
               w_nxt   = TRAP;
               w_cause = 2'd1;
            end else w_nxt = EXEC;
         end
         EXEC: begin
            if (w_br)              w_nxt = FETCH;
            else if (w_ld | w_st)  w_nxt = MEM;
            else                   w_nxt = WB;
         end
         MEM: begin
            if (dmem_ack) w_nxt = w_st ? FETCH : WB;
            else if (w_tmo) begin
               w_nxt   = TRAP;
               w_cause = 2'd3;
            end
         end
         WB:      w_nxt = FETCH;
         TRAP:    w_nxt = TRAP;
         default: w_nxt = FETCH;
      endcase
   end

   always_comb begin
      w_ireq   = 1'b0;
      w_irw    = 1'b0;
      w_dreq   = 1'b0;
      w_dwe    = 1'b0;
      w_pcw    = 1'b0;
      w_pcs    = 1'b0;
      w_rfw    = 1'b0;
      w_retire = 1'b0;
      unique case (r_state)
         FETCH: begin
            w_ireq = 1'b1;
            w_irw  = imem_ack;
         end
         EXEC: begin
            if (w_br) begin
               w_pcw    = 1'b1;
               w_pcs    = branch_taken;
               w_retire = 1'b1;
            end
         end
         MEM: begin
            w_dreq = 1'b1;
            w_dwe  = w_st;
            if (dmem_ack && w_st) begin
               w_pcw    = 1'b1;
               w_retire = 1'b1;
            end
         end
         WB: begin
            w_rfw    = 1'b1;
            w_pcw    = 1'b1;
            w_pcs    = w_jal | w_jalr;
            w_retire = 1'b1;
         end
         default: ;
      endcase
   end

   assign w_sel_on = (r_state != FETCH) && (r_state != TRAP);

   assign imem_req = w_ireq & rst_n;
   assign ir_wen   = w_irw & rst_n;
   assign dmem_req = w_dreq & rst_n;
   assign dmem_we  = w_dwe & rst_n;
   assign pc_wen   = w_pcw & rst_n;
   assign rf_wen   = w_rfw & rst_n;
   assign pc_sel   = w_pcs;

   assign wb_sel   = !w_sel_on ? 2'd0 :
                     w_lui ? 2'd3 :
                     (w_jal | w_jalr) ? 2'd0 :
                     w_ld ? 2'd2 : 2'd1;
   assign imm_op   = w_sel_on ? w_imm : 3'd0;
   assign alu_op   = w_sel_on ? w_alu : 4'd0;
   assign alua_sel = w_sel_on & ~(w_jal | w_auipc | w_br);
   assign alub_sel = w_sel_on & w_r;

   assign state      = r_state;
   assign trap       = r_trap;
   assign trap_cause = r_cause;
   assign retire_cnt = r_cnt;

endmodule
